// File: rtl/square_composer.sv
// square_composer: rebuilds radicand = root*root + remainder, one root bit per clock.
// Optional SQUARE_COMPOSER_CHECK_EN adds rem_err, flagging remainder > 2*root.
module square_composer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic [WIDTH-1:0]     root,
  input  logic [2*WIDTH-1:0]   remainder,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [2*WIDTH-1:0]   radicand,
  output logic                 overflow
`ifdef SQUARE_COMPOSER_CHECK_EN
  ,
  output logic                 rem_err
`endif
);
  localparam int AW = 2*WIDTH+1;
  localparam int CW = $clog2(WIDTH+1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] root_reg;
  logic [AW-1:0]  acc, addend, sum;
  logic           accept, last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    din_ready  = state == IDLE;
    dout_valid = state == DONE;
    accept     = din_ready && din_valid;
    last       = state == CALC && cnt == CW'(WIDTH-1);
    sum        = acc + (root_reg[0] ? addend : '0);
    state_nx   = accept ? CALC : last ? DONE : (dout_valid && dout_ready) ? IDLE : state;
  end
  // root_reg shifts right and addend left, so bit i of the root meets root << i
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt      <= '0;
      root_reg <= '0;
      acc      <= '0;
      addend   <= '0;
      radicand <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      root_reg <= root;
      acc      <= AW'(remainder);
      addend   <= AW'(root);
    end else if (state == CALC) begin
      cnt      <= cnt + CW'(1);
      root_reg <= root_reg >> 1;
      acc      <= sum;
      addend   <= addend << 1;
      if (last) begin
        radicand <= sum[2*WIDTH-1:0];
        overflow <= sum[AW-1];
      end
    end
`ifdef SQUARE_COMPOSER_CHECK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rem_err <= 1'b0;
    else if (accept) rem_err <= AW'(remainder) > (AW'(root) << 1);
`endif
endmodule

// File: tb/tb_square_composer.sv
// tb_square_composer: directed checks of square_composer at WIDTH=4.
// Build with SQUARE_COMPOSER_CHECK_EN defined to also check rem_err.
module tb_square_composer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [3:0] root = '0;
  logic [7:0] remainder = '0;
  logic       dout_valid;
  logic       dout_ready = 1'b1;
  logic [7:0] radicand;
  logic       overflow;
  logic       rem_err;
  int n_chk = 0;
  int n_fail = 0;

  square_composer #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_ready(din_ready),
    .root(root), .remainder(remainder), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .radicand(radicand), .overflow(overflow)
`ifdef SQUARE_COMPOSER_CHECK_EN
    , .rem_err(rem_err)
`endif
  );
`ifndef SQUARE_COMPOSER_CHECK_EN
  assign rem_err = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // drive one transaction; hold = cycles dout_ready stays low once DONE is reached
  task automatic run(input string tag, input logic [3:0] r, input logic [7:0] m,
                     input logic [7:0] er, input logic eo, input logic ee, input int hold);
    int lat;
    int lows;
    @(negedge clk);
    chk({tag, " din_ready before"}, din_ready, 1);
    din_valid  = 1'b1;
    root       = r;
    remainder  = m;
    dout_ready = (hold == 0);
    @(negedge clk);
    din_valid = 1'b0;
    root      = ~r;
    remainder = ~m;
    lat  = 0;
    lows = 0;
    while (!dout_valid && lat < 20) begin
      if (!din_ready) lows++;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, 4);
    chk({tag, " radicand"}, radicand, er);
    chk({tag, " overflow"}, overflow, eo);
`ifdef SQUARE_COMPOSER_CHECK_EN
    chk({tag, " rem_err"}, rem_err, ee);
`endif
    for (int h = 0; h < hold; h++) begin
      if (!din_ready) lows++;
      din_valid = (h == 2);
      root      = 4'd1;
      remainder = 8'd1;
      @(negedge clk);
      chk({tag, " held valid"}, dout_valid, 1);
      chk({tag, " held radicand"}, radicand, er);
      chk({tag, " held din_ready"}, din_ready, 0);
    end
    din_valid = 1'b0;
    if (!din_ready) lows++;
    dout_ready = 1'b1;
    @(negedge clk);
    chk({tag, " din_ready low cycles"}, lows, 5 + hold);
    chk({tag, " valid after handshake"}, dout_valid, 0);
    chk({tag, " ready after handshake"}, din_ready, 1);
    chk({tag, " radicand after handshake"}, radicand, er);
    chk({tag, " overflow after handshake"}, overflow, eo);
  endtask

  initial begin
    #2;
    chk("reset din_ready", din_ready, 1);
    chk("reset dout_valid", dout_valid, 0);
    chk("reset radicand", radicand, 0);
    chk("reset overflow", overflow, 0);
    chk("reset rem_err", rem_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run("r15m30", 4'd15, 8'd30, 8'd255, 1'b0, 1'b0, 0);
    run("r5m3", 4'd5, 8'd3, 8'd28, 1'b0, 1'b0, 0);
    run("r15m255", 4'd15, 8'd255, 8'd224, 1'b1, 1'b1, 0);
    run("r0m0", 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, 0);
    run("r0m7", 4'd0, 8'd7, 8'd7, 1'b0, 1'b1, 0);
    run("r9m4", 4'd9, 8'd4, 8'd85, 1'b0, 1'b0, 5);
    // the pulse during the hold window must not have started a transaction
    @(negedge clk);
    chk("no stray accept", din_ready, 1);
    chk("no stray result", dout_valid, 0);
    // mid-calculation abort
    din_valid = 1'b1;
    root      = 4'd12;
    remainder = 8'd0;
    @(posedge clk);
    #1 din_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort dout_valid", dout_valid, 0);
    chk("abort din_ready", din_ready, 1);
    chk("abort radicand", radicand, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort no emit", dout_valid, 0);
    end
    run("r3m1", 4'd3, 8'd1, 8'd10, 1'b0, 1'b0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
